clock_set_ctrl: RTL and testbench

Mode and time-set controller for the digital clock datapath. Converts the 1 Hz tick and two debounced push-buttons into enable, increment and load strobes for the cascaded seconds/minutes/hours counters (load/en/Q/Co style counters). Sits between the button front-end and the counter chain and drives the display blank signal for the field being edited.

---
 rtl/clock_set_ctrl.sv | 136 +++++++++++++
 tb/tb_clock_set_ctrl.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/clock_set_ctrl.sv
// Mode/time-set controller: turns the 1 Hz tick and mode/inc buttons into counter strobes.
// Optional auto-repeat on a held inc key is compiled in with CLKCTL_AUTOREPEAT_EN.
//
// state   | meaning
// RUN     | time advances on tick, inc key ignored
// SET_HR  | time frozen, inc presses step hours, field blinks
// SET_MIN | time frozen, inc presses step minutes, field blinks
module clock_set_ctrl #(
    parameter int TIMEOUT    = 30,
    parameter int REPEAT_DLY = 2
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       tick,
    input  logic       key_mode,
    input  logic       key_inc,
    output logic       sec_en,
    output logic       min_en,
    output logic       hr_en,
    output logic       sec_load,
    output logic [1:0] mode,
    output logic       blink
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_HR  = 2'd1,
        SET_MIN = 2'd2
    } state_t;

    if (TIMEOUT < 1 || TIMEOUT > 255 || REPEAT_DLY < 1 || REPEAT_DLY > 15) begin : g_bad_param
        $error("clock_set_ctrl: TIMEOUT or REPEAT_DLY out of range");
    end

    state_t     state, state_nx;
    logic       mode_q, mode_prev, inc_q, inc_prev;
    logic [7:0] to_cnt, to_nx;
    logic       blink_nx, sec_en_nx, hr_en_nx, min_en_nx, sec_load_nx;
    logic       mode_press, inc_press, in_set, rpt, inc_evt;

    // Previous levels start at 1 so a key held through reset is not a press.
    assign mode_press = mode_q & ~mode_prev;
    assign inc_press  = inc_q & ~inc_prev;
    assign in_set     = (state == SET_HR) || (state == SET_MIN);
    assign inc_evt    = inc_press | rpt;
    assign mode       = state;

`ifdef CLKCTL_AUTOREPEAT_EN
    logic [3:0] hold_cnt, hold_nx;

    assign rpt = in_set & inc_q & tick & (hold_cnt == 4'(REPEAT_DLY));

    always_comb begin
        hold_nx = 4'd0;
        if (in_set && inc_q && state_nx == state)
            hold_nx = (tick && !rpt) ? hold_cnt + 4'd1 : hold_cnt;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) hold_cnt <= 4'd0;
        else       hold_cnt <= hold_nx;
    end
`else
    assign rpt = 1'b0;
`endif

    always_comb begin
        state_nx    = state;
        to_nx       = to_cnt;
        blink_nx    = 1'b0;
        sec_en_nx   = 1'b0;
        hr_en_nx    = 1'b0;
        min_en_nx   = 1'b0;
        sec_load_nx = 1'b0;
        case (state)
            RUN: begin
                sec_en_nx = tick;
                to_nx     = 8'd0;
                if (mode_press) state_nx = SET_HR;
            end
            SET_HR, SET_MIN: begin
                blink_nx = blink ^ tick;
                to_nx    = to_cnt + 8'(tick);
                // Mode beats inc; any key beats the timeout.
                if (mode_press) begin
                    state_nx    = (state == SET_HR) ? SET_MIN : RUN;
                    sec_load_nx = (state == SET_MIN);
                    blink_nx    = 1'b0;
                    to_nx       = 8'd0;
                end else if (inc_evt) begin
                    hr_en_nx  = (state == SET_HR);
                    min_en_nx = (state == SET_MIN);
                    to_nx     = 8'd0;
                end else if (tick && to_cnt == 8'(TIMEOUT - 1)) begin
                    state_nx    = RUN;
                    sec_load_nx = 1'b1;
                    blink_nx    = 1'b0;
                    to_nx       = 8'd0;
                end
            end
            default: begin
                state_nx = RUN;
                to_nx    = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state     <= RUN;
            mode_q    <= 1'b1;
            mode_prev <= 1'b1;
            inc_q     <= 1'b1;
            inc_prev  <= 1'b1;
            to_cnt    <= 8'd0;
            blink     <= 1'b0;
            sec_en    <= 1'b0;
            hr_en     <= 1'b0;
            min_en    <= 1'b0;
            sec_load  <= 1'b0;
        end else begin
            state     <= state_nx;
            mode_q    <= key_mode;
            mode_prev <= mode_q;
            inc_q     <= key_inc;
            inc_prev  <= inc_q;
            to_cnt    <= to_nx;
            blink     <= blink_nx;
            sec_en    <= sec_en_nx;
            hr_en     <= hr_en_nx;
            min_en    <= min_en_nx;
            sec_load  <= sec_load_nx;
        end
    end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl: per-cycle vector table plus timeout, repeat and reset sequences.
module tb_clock_set_ctrl;
    logic       clk = 1'b0, clrn = 1'b0, tick = 1'b0, key_mode = 1'b0, key_inc = 1'b0;
    logic       sec_en, min_en, hr_en, sec_load, blink;
    logic [1:0] mode;
    int         checks = 0, errors = 0;
    int         n_sec = 0, n_hr = 0, n_min = 0, n_load = 0;

    // exp packs {sec_en, hr_en, min_en, sec_load, mode[1:0], blink} after the edge
    typedef struct packed {
        logic       t;
        logic       km;
        logic       ki;
        logic [6:0] exp;
    } vec_t;
    vec_t vq[$];

    clock_set_ctrl dut (
        .clk(clk), .clrn(clrn), .tick(tick), .key_mode(key_mode), .key_inc(key_inc),
        .sec_en(sec_en), .min_en(min_en), .hr_en(hr_en), .sec_load(sec_load),
        .mode(mode), .blink(blink)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic t, input logic km, input logic ki, input logic [6:0] e);
        vec_t v;
        v.t = t; v.km = km; v.ki = ki; v.exp = e;
        return v;
    endfunction

    function automatic logic [6:0] outs();
        return {sec_en, hr_en, min_en, sec_load, mode, blink};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic t, input logic km, input logic ki);
        @(negedge clk);
        tick = t; key_mode = km; key_inc = ki;
        @(posedge clk);
        #1;
        n_sec  += int'(sec_en);
        n_hr   += int'(hr_en);
        n_min  += int'(min_en);
        n_load += int'(sec_load);
        check("strobe_exclusive", 32'((int'(sec_en) + int'(hr_en) + int'(min_en)) <= 1), 32'd1);
    endtask

    initial begin
        int exp_rep;
        vq.push_back(mk(0, 0, 0, 7'b0000_00_0));
        vq.push_back(mk(1, 0, 0, 7'b1000_00_0));
        vq.push_back(mk(0, 0, 0, 7'b0000_00_0));
        vq.push_back(mk(1, 0, 0, 7'b1000_00_0));
        vq.push_back(mk(0, 0, 1, 7'b0000_00_0));
        vq.push_back(mk(0, 0, 0, 7'b0000_00_0));
        vq.push_back(mk(0, 1, 0, 7'b0000_00_0));
        vq.push_back(mk(0, 0, 0, 7'b0000_01_0));
        vq.push_back(mk(1, 0, 0, 7'b0000_01_1));
        vq.push_back(mk(0, 0, 1, 7'b0000_01_1));
        vq.push_back(mk(0, 0, 0, 7'b0100_01_1));
        vq.push_back(mk(0, 0, 1, 7'b0000_01_1));
        vq.push_back(mk(1, 0, 0, 7'b0100_01_0));
        vq.push_back(mk(0, 0, 0, 7'b0000_01_0));
        vq.push_back(mk(0, 1, 1, 7'b0000_01_0));
        vq.push_back(mk(0, 0, 0, 7'b0000_10_0));
        vq.push_back(mk(0, 0, 1, 7'b0000_10_0));
        vq.push_back(mk(0, 0, 0, 7'b0010_10_0));
        vq.push_back(mk(0, 1, 0, 7'b0000_10_0));
        vq.push_back(mk(0, 0, 0, 7'b0001_00_0));
        vq.push_back(mk(1, 0, 0, 7'b1000_00_0));
        vq.push_back(mk(0, 0, 0, 7'b0000_00_0));

        repeat (2) @(posedge clk);
        #1;
        check("reset_outs", 32'(outs()), 32'd0);
        @(negedge clk);
        clrn = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            step(vq[i].t, vq[i].km, vq[i].ki);
            check($sformatf("vec%0d", i), 32'(outs()), 32'(vq[i].exp));
        end

        // Timeout: 30 idle ticks in SET_HR
        step(0, 1, 0);
        step(0, 0, 0);
        check("to_enter", 32'(outs()), 32'(7'b0000_01_0));
        for (int k = 1; k <= 30; k++) begin
            logic b;
            b = k[0];
            step(1, 0, 0);
            if (k < 30) check($sformatf("to_tick%0d", k), 32'(outs()), 32'({6'b0000_01, b}));
            else        check("to_expire", 32'(outs()), 32'(7'b0001_00_0));
            step(0, 0, 0);
        end
        check("to_after", 32'(outs()), 32'd0);

        // Held inc in SET_MIN across 6 ticks
        step(0, 1, 0);
        step(0, 0, 0);
        step(0, 1, 0);
        step(0, 0, 0);
        check("rp_mode", 32'(mode), 32'd2);
        n_sec = 0; n_hr = 0; n_min = 0; n_load = 0;
        step(0, 0, 1);
        step(0, 0, 1);
        for (int k = 0; k < 6; k++) begin
            step(1, 0, 1);
            step(0, 0, 1);
            step(0, 0, 1);
        end
        repeat (3) step(0, 0, 0);
`ifdef CLKCTL_AUTOREPEAT_EN
        exp_rep = 5;
`else
        exp_rep = 1;
`endif
        check("rp_min_count", 32'(n_min), 32'(exp_rep));
        check("rp_other", 32'(n_hr + n_sec + n_load), 32'd0);
        check("rp_mode_after", 32'(mode), 32'd2);

        // Reset mid-operation with key_mode held through release
        @(negedge clk);
        key_mode = 1'b1;
        #2 clrn = 1'b0;
        #1 check("async_reset", 32'(outs()), 32'd0);
        repeat (2) @(negedge clk);
        clrn = 1'b1;
        n_load = 0;
        for (int k = 0; k < 6; k++) begin
            step(0, 1, 0);
            check($sformatf("held_mode%0d", k), 32'(mode), 32'd0);
        end
        check("held_no_load", 32'(n_load), 32'd0);
        step(0, 0, 0);
        step(0, 0, 0);
        step(0, 1, 0);
        step(0, 0, 0);
        check("repress_mode", 32'(mode), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
